board_row_fetcher: RTL and testbench
====================================

# board_row_fetcher

Upstream feeder for the VGA colour mapper. On each row-load request it reads the 10 cells of one board row from the board RAM and overlays the active falling piece. It assembles the cells into a back buffer, then swaps them into the `Row` output array in one cycle, so the mapper never sees a half-written row. It sits between the board RAM / piece logic and `color_mapper` (consuming `LD_Row`/`rowNum`, producing `Row`/`rowReady`).

## Interface
- `BOARD_W`, 10, cells per row
- `BOARD_H`, 20, rows on board; valid `rowNum` is 0..19
- `CELL_W`, 16, cell word width; bits [11:0] = RGB444, [15:12] reserved and passed through
- `ADDR_W`, 8, board RAM address width
- `Clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `LD_Row`  in  1  row-load request from the colour mapper; level signal, may stay high for many cycles
- `rowNum`  in  8  board row to fetch, sampled at request start
- `mem_addr`  out  ADDR_W  board RAM read address; RAM has 1-cycle synchronous read latency
- `mem_rdata`  in  CELL_W  RAM read data for the address presented on the previous cycle
- `piece_x[4]`  in  4  column of each active-piece block
- `piece_y[4]`  in  5  row of each active-piece block
- `piece_color`  in  CELL_W  cell word drawn for active-piece blocks
- `piece_valid`  in  1  an active piece exists
- `Row[BOARD_W]`  out  CELL_W  front buffer, read by the colour mapper
- `rowReady`  out  1  one-cycle pulse in the cycle after the front buffer updates
- `busy`  out  1  fetch in progress
- `overrun`  out  1  sticky; a request arrived while busy; cleared only by reset

## Operation
- FSM states (`fetch_state_t`): IDLE, FETCH, DRAIN, SWAP.
- Start condition: a rising edge of `LD_Row` (registered previous value is 0, current is 1) while in IDLE.
- On start:
  - Latch `rowNum` into `row_q`.
  - Snapshot `piece_x`, `piece_y`, `piece_color`, `piece_valid`.
  - Set `base = (rowNum<<3)+(rowNum<<1)`, truncated to ADDR_W.
  - Set column counter `col` = 0.
  - Go to FETCH.
- FETCH:
  - `mem_addr = base + col`.
  - `col` increments each cycle.
  - After `col` = BOARD_W-1 is issued, go to DRAIN.
- Capture: each `mem_rdata` is written to `back[col_d]`, where `col_d` is `col` delayed by one cycle.
  - If the snapshot piece is valid and any k has `piece_x[k]==col_d` and `piece_y[k]==row_q`, write `piece_color` instead of `mem_rdata`.
  - If `row_q >= BOARD_H`, write 0 regardless of RAM data or piece. Addresses are still issued so latency stays fixed.
- DRAIN: one cycle to capture the last cell; then go to SWAP.
- SWAP: `Row <= back` (all cells in one cycle); go to IDLE.
- `rowReady` is high for exactly the cycle after SWAP.
- `busy` is high in FETCH, DRAIN and SWAP.
- A rising edge of `LD_Row` outside IDLE is ignored; it sets `overrun`. A level held high across a completed fetch does not retrigger.
- Reset values: `Row` all 0, back buffer 0, `rowReady` 0, `busy` 0, `mem_addr` 0, `overrun` 0, state IDLE, edge-detect register 0.
- Reset mid-fetch aborts the fetch immediately; the front buffer is zeroed.

## Timing
- Cycle 0: `LD_Row` rising edge sampled.
- Cycles 1..10: FETCH, addresses `base`..`base+9`.
- Cycles 2..11: data captured; cycle 11 is DRAIN.
- Cycle 12: SWAP; `Row` updates at the end of cycle 12.
- Cycle 13: `rowReady` = 1; `busy` = 0.
- Earliest next accepted start is cycle 13.
- Total request-to-valid latency: 13 cycles, fixed.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `tetris_pkg`:
  - `BOARD_W`, `BOARD_H`.
  - `cell_t` (logic [15:0]).
  - `fetch_state_t` enum.
- One sub-module, `cell_overlay` (combinational):
  - Inputs: raw cell, `col_d`, `row_q`, piece snapshot.
  - Output: final cell word, including the out-of-range zeroing.

## Test plan
- Reset, then RAM row 3 filled with 0x0F00..0x0F09, no piece; `LD_Row` 0→1 with `rowNum`=3 → `mem_addr` 30..39 on cycles 1..10; `Row[i]`=0x0F00+i at cycle 12; `rowReady` pulses at cycle 13.
- Piece valid, blocks at (4,5),(5,5),(6,5),(5,6), `piece_color`=0x00F0; fetch row 5 → `Row[4..6]`=0x00F0, other cells equal RAM contents.
- `rowNum`=0 and `rowNum`=19 → addresses 0..9 and 190..199; `rowNum`=25 → all `Row` cells 0, same 13-cycle latency.
- `LD_Row` held high for 40 cycles → exactly one fetch, one `rowReady` pulse, `overrun` stays 0.
- Second rising edge at cycle 5 of a fetch → ignored, `overrun`=1; first fetch result unchanged.
- Assert `reset` at cycle 6 of a fetch → next cycle `Row` all 0, `busy` 0, no `rowReady` pulse.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, cell word type and row-fetch FSM encoding.
// Used by the row fetcher, its overlay helper and its interface.
package tetris_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int CELL_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int ROW_W   = 8;
  localparam int COL_W   = 4;
  localparam int NBLK    = 4;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} fetch_state_t;

  typedef struct packed {
    logic                       valid;
    cell_t                      color;
    logic [NBLK-1:0][COL_W-1:0] x;
    logic [NBLK-1:0][4:0]       y;
  } piece_t;

  // First RAM address of a row: row*10, wrapped to the address width.
  function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] r);
    logic [ROW_W+2:0] s;
    s = {r, 3'b000} + {2'b00, r, 1'b0};
    return s[ADDR_W-1:0];
  endfunction
endpackage

// File: rtl/board_row_fetcher_if.sv
// Row request / row result bundle between the colour mapper and the row fetcher.
// Master is the mapper side, slave is the fetcher side.
interface board_row_fetcher_if;
  import tetris_pkg::*;

  logic             LD_Row;
  logic [ROW_W-1:0] rowNum;
  cell_t            Row [BOARD_W];
  logic             rowReady;
  logic             busy;
  logic             overrun;

  modport master (output LD_Row, rowNum, input Row, rowReady, busy, overrun);
  modport slave  (input LD_Row, rowNum, output Row, rowReady, busy, overrun);
endinterface

// File: rtl/board_row_fetcher_overlay.sv
// Combinational: final cell word for one captured RAM word, painting the piece
// snapshot over it and blanking rows that lie off the board.
module cell_overlay
  import tetris_pkg::*;
(
  input  cell_t            raw_i,
  input  logic [COL_W-1:0] col_i,
  input  logic [ROW_W-1:0] row_i,
  input  piece_t           piece_i,
  output cell_t            cell_o
);
  logic hit;

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      if (piece_i.x[k] == col_i && {3'b000, piece_i.y[k]} == row_i) hit = 1'b1;
    end
    cell_o = raw_i;
    if (piece_i.valid && hit) cell_o = piece_i.color;
    if (row_i >= ROW_W'(BOARD_H)) cell_o = '0;
  end
endmodule

// File: rtl/board_row_fetcher.sv
// Fetches one board row (RAM + piece overlay) into a back buffer, then swaps it whole
// into Row; fixed 13-cycle request-to-rowReady latency, requests while busy are dropped and flag overrun.
module board_row_fetcher
  import tetris_pkg::*;
(
  input  logic                  Clk,
  input  logic                  reset,
  board_row_fetcher_if.slave    fif,
  output logic [ADDR_W-1:0]     mem_addr,
  input  cell_t                 mem_rdata,
  input  logic [COL_W-1:0]      piece_x [NBLK],
  input  logic [4:0]            piece_y [NBLK],
  input  cell_t                 piece_color,
  input  logic                  piece_valid
);
  fetch_state_t      state_q, state_d;
  logic              ld_q, ld_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [COL_W-1:0]  cap_col_q, cap_col_d;
  logic              cap_vld_q, cap_vld_d;
  piece_t            piece_q, piece_d, piece_in;
  cell_t             back_q [BOARD_W];
  cell_t             back_d [BOARD_W];
  cell_t             front_q [BOARD_W];
  cell_t             front_d [BOARD_W];
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              rise;
  cell_t             cap_cell;

  cell_overlay u_overlay (
    .raw_i   (mem_rdata),
    .col_i   (cap_col_q),
    .row_i   (row_q),
    .piece_i (piece_q),
    .cell_o  (cap_cell)
  );

  always_comb begin
    piece_in       = '0;
    piece_in.valid = piece_valid;
    piece_in.color = piece_color;
    for (int k = 0; k < NBLK; k++) begin
      piece_in.x[k] = piece_x[k];
      piece_in.y[k] = piece_y[k];
    end
  end

  assign rise = fif.LD_Row & ~ld_q;

  always_comb begin
    state_d   = state_q;
    ld_d      = fif.LD_Row;
    row_d     = row_q;
    base_d    = base_q;
    addr_d    = addr_q;
    col_d     = col_q;
    cap_col_d = cap_col_q;
    cap_vld_d = 1'b0;
    piece_d   = piece_q;
    back_d    = back_q;
    front_d   = front_q;
    rdy_d     = 1'b0;
    ovr_d     = ovr_q;

    // Capture trails the address by one cycle to cover the RAM read latency.
    if (cap_vld_q) back_d[cap_col_q] = cap_cell;

    case (state_q)
      IDLE: begin
        if (rise) begin
          row_d   = fif.rowNum;
          piece_d = piece_in;
          base_d  = row_base(fif.rowNum);
          addr_d  = row_base(fif.rowNum);
          col_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        cap_vld_d = 1'b1;
        cap_col_d = col_q;
        col_d     = col_q + COL_W'(1);
        if (col_q == COL_W'(BOARD_W - 1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = base_q + ADDR_W'(col_q) + ADDR_W'(1);
        end
      end
      DRAIN: state_d = SWAP;
      SWAP: begin
        front_d = back_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rise && state_q != IDLE) ovr_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ld_q      <= 1'b0;
      row_q     <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      col_q     <= '0;
      cap_col_q <= '0;
      cap_vld_q <= 1'b0;
      piece_q   <= '0;
      back_q    <= '{default: '0};
      front_q   <= '{default: '0};
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_q      <= ld_d;
      row_q     <= row_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      col_q     <= col_d;
      cap_col_q <= cap_col_d;
      cap_vld_q <= cap_vld_d;
      piece_q   <= piece_d;
      back_q    <= back_d;
      front_q   <= front_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
    end
  end

  assign mem_addr     = addr_q;
  assign fif.Row      = front_q;
  assign fif.rowReady = rdy_q;
  assign fif.busy     = busy_q;
  assign fif.overrun  = ovr_q;
endmodule

// File: tb/tb_board_row_fetcher.sv
// Directed plus randomized bench for board_row_fetcher against a painted-board model.
module tb_board_row_fetcher;
  import tetris_pkg::*;

  logic              Clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_addr;
  cell_t             mem_rdata;
  logic [COL_W-1:0]  piece_x [NBLK];
  logic [4:0]        piece_y [NBLK];
  cell_t             piece_color;
  logic              piece_valid;

  cell_t ram [256];
  cell_t exp_row [BOARD_W];
  int    checks = 0;
  int    errors = 0;
  int    pulses;

  board_row_fetcher_if bif ();

  board_row_fetcher dut (
    .Clk         (Clk),
    .reset       (reset),
    .fif         (bif),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .piece_x     (piece_x),
    .piece_y     (piece_y),
    .piece_color (piece_color),
    .piece_valid (piece_valid)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) mem_rdata <= ram[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: the row as stored in RAM, with the current piece painted on top;
  // rows off the board read back as blank.
  task automatic calc_exp(input int row);
    for (int c = 0; c < BOARD_W; c++) exp_row[c] = ram[(row * BOARD_W + c) % 256];
    if (piece_valid) begin
      for (int k = 0; k < NBLK; k++) begin
        if (int'(piece_y[k]) == row && int'(piece_x[k]) < BOARD_W) exp_row[piece_x[k]] = piece_color;
      end
    end
    if (row >= BOARD_H) for (int c = 0; c < BOARD_W; c++) exp_row[c] = '0;
  endtask

  task automatic scramble_piece();
    for (int k = 0; k < NBLK; k++) begin
      piece_x[k] = COL_W'($urandom_range(0, 11));
      piece_y[k] = 5'($urandom_range(0, 31));
    end
    piece_color = cell_t'($urandom);
    piece_valid = 1'($urandom);
  endtask

  // Full request: rise at cycle 0, checks cycles 1..14. reraise_at >= 0 drops
  // LD_Row two cycles earlier and raises it again at that cycle.
  task automatic run_fetch(input int row, input int reraise_at, input logic ovr_in);
    int   base;
    logic exp_ovr;
    calc_exp(row);
    base    = (row * BOARD_W) % 256;
    exp_ovr = ovr_in;
    @(negedge Clk);
    bif.rowNum = ROW_W'(row);
    bif.LD_Row = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      if (reraise_at >= 0 && k > reraise_at) exp_ovr = 1'b1;
      if (k <= 10) chk("mem_addr", 32'(mem_addr), 32'((base + k - 1) % 256));
      chk("busy", 32'(bif.busy), 32'(k <= 12));
      chk("rowReady", 32'(bif.rowReady), 32'(k == 13));
      chk("overrun", 32'(bif.overrun), 32'(exp_ovr));
      if (k == 13) for (int c = 0; c < BOARD_W; c++) chk("Row", 32'(bif.Row[c]), 32'(exp_row[c]));
      if (k == 2) scramble_piece();
      if (reraise_at >= 0 && k == reraise_at - 2) bif.LD_Row = 1'b0;
      if (reraise_at >= 0 && k == reraise_at) bif.LD_Row = 1'b1;
    end
    bif.LD_Row = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bif.LD_Row = 1'b0;
    bif.rowNum = '0;
    for (int i = 0; i < 256; i++) ram[i] = cell_t'($urandom);
    for (int k = 0; k < NBLK; k++) begin
      piece_x[k] = '0;
      piece_y[k] = '0;
    end
    piece_color = '0;
    piece_valid = 1'b0;

    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(bif.busy), 0);
    chk("rst_rowReady", 32'(bif.rowReady), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_overrun", 32'(bif.overrun), 0);
    for (int c = 0; c < BOARD_W; c++) chk("rst_Row", 32'(bif.Row[c]), 0);
    reset = 1'b0;
    @(negedge Clk);

    // Row 3 with a known ramp, no piece.
    for (int i = 0; i < BOARD_W; i++) ram[30 + i] = cell_t'(16'h0F00 + i);
    run_fetch(3, -1, 1'b0);

    // T-piece on row 5.
    piece_valid = 1'b1;
    piece_color = 16'h00F0;
    piece_x[0] = 4; piece_y[0] = 5;
    piece_x[1] = 5; piece_y[1] = 5;
    piece_x[2] = 6; piece_y[2] = 5;
    piece_x[3] = 5; piece_y[3] = 6;
    run_fetch(5, -1, 1'b0);

    // Board edges and an off-board row.
    run_fetch(0, -1, 1'b0);
    run_fetch(19, -1, 1'b0);
    run_fetch(25, -1, 1'b0);

    // Level held high across a whole fetch: exactly one result.
    calc_exp(7);
    pulses = 0;
    @(negedge Clk);
    bif.rowNum = 8'd7;
    bif.LD_Row = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge Clk);
      if (bif.rowReady) pulses++;
      if (k == 40) bif.LD_Row = 1'b0;
    end
    chk("held_pulses", 32'(pulses), 1);
    chk("held_overrun", 32'(bif.overrun), 0);
    for (int c = 0; c < BOARD_W; c++) chk("held_Row", 32'(bif.Row[c]), 32'(exp_row[c]));

    // Randomized rows and pieces, biased so the piece often lands on the row.
    for (int n = 0; n < 20; n++) begin
      int row;
      row = $urandom_range(0, 30);
      scramble_piece();
      for (int k = 0; k < NBLK; k++) begin
        if ($urandom_range(0, 1) == 1) piece_y[k] = 5'(row);
      end
      run_fetch(row, -1, 1'b0);
    end

    // Second request mid-fetch is dropped and flagged.
    scramble_piece();
    run_fetch(11, 5, 1'b0);

    // Reset mid-fetch.
    @(negedge Clk);
    bif.rowNum = 8'd2;
    bif.LD_Row = 1'b1;
    repeat (6) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_busy", 32'(bif.busy), 0);
    chk("mid_rst_rowReady", 32'(bif.rowReady), 0);
    chk("mid_rst_overrun", 32'(bif.overrun), 0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 0);
    for (int c = 0; c < BOARD_W; c++) chk("mid_rst_Row", 32'(bif.Row[c]), 0);
    reset      = 1'b0;
    bif.LD_Row = 1'b0;
    pulses     = 0;
    repeat (16) begin
      @(negedge Clk);
      if (bif.rowReady || bif.busy) pulses++;
    end
    chk("post_rst_quiet", 32'(pulses), 0);

    // Recovery after reset.
    run_fetch(14, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
